// File: rtl/sa_gemm_core.sv
// Output-stationary N x N systolic GEMM core: skewed A/B lanes feed a PE grid
// that accumulates C = sum_k a_k b_k^T, then streams C out row by row.
// Optional build macro SA_SATURATE_EN: saturating accumulators plus sticky ovf.
module sa_gemm_core #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DW-1:0]         in_a,
    input  logic [N*DW-1:0]         in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*AW-1:0]         out_data,
    output logic [$clog2(N)-1:0]    out_row,
    output logic                    out_last,
    output logic                    busy,
    output logic                    ovf
);

    localparam int RW        = $clog2(N);
    localparam int DRAIN_CYC = 3 * N - 2;
    localparam int CW        = $clog2(DRAIN_CYC);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUTPUT
    } state_t;

    state_t          st_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            out_last_q;
    logic [RW-1:0]   out_row_q;
    logic [CW-1:0]   cnt_q;

    logic            beat_acc;
    logic            acc_clr;

    logic signed [DW-1:0] a_lane [N];
    logic signed [DW-1:0] b_lane [N];
    logic signed [DW-1:0] a_skew [N];
    logic signed [DW-1:0] b_skew [N];

    logic signed [DW-1:0] a_in   [N][N];
    logic signed [DW-1:0] b_in   [N][N];
    logic signed [DW-1:0] a_pe_q [N][N-1];
    logic signed [DW-1:0] b_pe_q [N-1][N];
    logic signed [AW-1:0] acc_q  [N][N];
    logic signed [AW-1:0] acc_d  [N][N];

    assign beat_acc = in_valid && in_ready_q;
    assign acc_clr  = (st_q == OUTPUT) && out_ready && out_last_q;

    // Lanes carry zeros whenever no beat is accepted, so the grid can free-run.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign a_lane[gi] = beat_acc ? in_a[gi*DW +: DW] : '0;
        assign b_lane[gi] = beat_acc ? in_b[gi*DW +: DW] : '0;

        if (gi == 0) begin : g_direct
            assign a_skew[gi] = a_lane[gi];
            assign b_skew[gi] = b_lane[gi];
        end else begin : g_delay
            logic signed [DW-1:0] a_sr_q [gi];
            logic signed [DW-1:0] b_sr_q [gi];

            // NOTE: the skew chains are cleared on reset so an aborted product
            // cannot leak stale operands into the next one.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int k = 0; k < gi; k++) begin
                        a_sr_q[k] <= '0;
                        b_sr_q[k] <= '0;
                    end
                end else begin
                    a_sr_q[0] <= a_lane[gi];
                    b_sr_q[0] <= b_lane[gi];
                    for (int k = 1; k < gi; k++) begin
                        a_sr_q[k] <= a_sr_q[k-1];
                        b_sr_q[k] <= b_sr_q[k-1];
                    end
                end
            end

            assign a_skew[gi] = a_sr_q[gi-1];
            assign b_skew[gi] = b_sr_q[gi-1];
        end
    end

`ifdef SA_SATURATE_EN
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    logic [N*N-1:0] ovf_hit;
    logic           ovf_q;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [2*DW-1:0] prod;
            logic signed [AW-1:0]   prod_ext;

            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_skew[gi];
            end else begin : g_a_link
                assign a_in[gi][gj] = a_pe_q[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_skew[gj];
            end else begin : g_b_link
                assign b_in[gi][gj] = b_pe_q[gi-1][gj];
            end

            assign prod     = a_in[gi][gj] * b_in[gi][gj];
            assign prod_ext = AW'(prod);

`ifdef SA_SATURATE_EN
            logic signed [AW:0] sum;
            assign sum = {acc_q[gi][gj][AW-1], acc_q[gi][gj]} + {prod_ext[AW-1], prod_ext};
            assign ovf_hit[gi*N+gj] = sum[AW] ^ sum[AW-1];
            assign acc_d[gi][gj] = (sum[AW] ^ sum[AW-1]) ? (sum[AW] ? ACC_MIN : ACC_MAX)
                                                         : sum[AW-1:0];
`else
            assign acc_d[gi][gj] = acc_q[gi][gj] + prod_ext;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                end
                for (int j = 0; j < N-1; j++) begin
                    a_pe_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_pe_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= acc_clr ? '0 : acc_d[i][j];
                end
                for (int j = 0; j < N-1; j++) begin
                    a_pe_q[i][j] <= a_in[i][j];
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_pe_q[i][j] <= b_in[i][j];
                end
            end
        end
    end

`ifdef SA_SATURATE_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (acc_clr) begin
            ovf_q <= 1'b0;
        end else if (|ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_q        <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (beat_acc) begin
                        busy_q <= 1'b1;
                        if (in_last) begin
                            st_q       <= DRAIN;
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            st_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (beat_acc && in_last) begin
                        st_q       <= DRAIN;
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                DRAIN: begin
                    // The last PE settles after 2N-2 edges; the full window is fixed.
                    if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                        st_q        <= OUTPUT;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        out_last_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            st_q        <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            out_row_q   <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_row_q  <= out_row_q + RW'(1);
                            out_last_q <= (out_row_q == RW'(N - 2));
                        end
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            out_data[j*AW +: AW] = acc_q[out_row_q][j];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_sa_gemm_core.sv
// Randomised self-checking bench for sa_gemm_core against a plain-arithmetic
// matrix-product model (wrap or saturate, following SA_SATURATE_EN).
module tb_sa_gemm_core;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 19;
    localparam int RW = $clog2(N);
    localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));

    typedef logic [N*DW-1:0] beat_t;
    typedef logic [N*AW-1:0] row_t;

    logic              CLK;
    logic              RST;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_a;
    logic [N*DW-1:0]   in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [N*AW-1:0]   out_data;
    logic [RW-1:0]     out_row;
    logic              out_last;
    logic              busy;
    logic              ovf;

    int     n_tests;
    int     n_fail;
    beat_t  qa[$];
    beat_t  qb[$];
    longint exp_c [N][N];
    bit     exp_ovf;
    row_t   first_row;

    sa_gemm_core #(.N(N), .DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(5))
                0:       b[i*DW +: DW] = 8'h80;
                1:       b[i*DW +: DW] = 8'h7f;
                default: b[i*DW +: DW] = DW'($urandom);
            endcase
        end
        return b;
    endfunction

    function automatic beat_t fill_beat(input logic [DW-1:0] v);
        beat_t b;
        for (int i = 0; i < N; i++) b[i*DW +: DW] = v;
        return b;
    endfunction

    // C[i][j] = sum_k A[i][k]*B[k][j]; saturation clamps step by step in k order.
    function automatic void model();
        logic signed [DW-1:0] ea;
        logic signed [DW-1:0] eb;
        longint acc;
        exp_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < qa.size(); k++) begin
                    ea = qa[k][i*DW +: DW];
                    eb = qb[k][j*DW +: DW];
                    acc = acc + longint'(ea) * longint'(eb);
`ifdef SA_SATURATE_EN
                    if (acc > ACC_MAX) begin acc = ACC_MAX; exp_ovf = 1'b1; end
                    if (acc < ACC_MIN) begin acc = ACC_MIN; exp_ovf = 1'b1; end
`endif
                end
`ifndef SA_SATURATE_EN
                acc = (acc <<< (64 - AW)) >>> (64 - AW);
`endif
                exp_c[i][j] = acc;
            end
        end
    endfunction

    function automatic row_t exp_row(input int r);
        row_t   v;
        longint e;
        for (int j = 0; j < N; j++) begin
            e = exp_c[r][j];
            v[j*AW +: AW] = e[AW-1:0];
        end
        return v;
    endfunction

    task automatic send_beats(input string name, input int bubble_pct);
        int guard;
        for (int k = 0; k < qa.size(); k++) begin
            if ($urandom_range(99) < bubble_pct) begin
                @(negedge CLK);
                in_valid = 1'b0;
                in_a     = rand_beat();
                in_b     = rand_beat();
                in_last  = 1'($urandom);
                @(posedge CLK);
            end
            @(negedge CLK);
            in_valid = 1'b1;
            in_a     = qa[k];
            in_b     = qb[k];
            in_last  = (k == qa.size() - 1);
            guard    = 0;
            while (!in_ready && guard < 50) begin
                @(posedge CLK);
                @(negedge CLK);
                guard++;
            end
            if (guard >= 50) check({name, "_ready_timeout"}, 0, 1);
            @(posedge CLK);
        end
    endtask

    task automatic collect(input string name, input int stall_row);
        int   lat;
        int   leak;
        logic [255:0] held;
        lat  = 0;
        leak = 0;
        @(negedge CLK);
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) leak++;
            in_valid = 1'b1;
            in_a     = rand_beat();
            in_b     = rand_beat();
            in_last  = 1'($urandom);
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        in_valid = 1'b0;
        check({name, "_latency"}, lat, 3 * N - 2);
        check({name, "_drain_ready_low"}, leak, 0);
        check({name, "_ovf"}, ovf, exp_ovf);
        first_row = out_data;
        for (int r = 0; r < N; r++) begin
            check({name, "_row_ctl"}, {out_valid, in_ready, busy, out_row, out_last},
                  {1'b1, 1'b0, 1'b1, RW'(r), (r == N - 1)});
            check($sformatf("%s_row%0d", name, r), out_data, exp_row(r));
            if (r == stall_row) begin
                out_ready = 1'b0;
                held = {out_valid, out_row, out_last, out_data};
                for (int s = 0; s < 5; s++) begin
                    @(posedge CLK);
                    @(negedge CLK);
                    check($sformatf("%s_stall%0d", name, s),
                          {out_valid, out_row, out_last, out_data}, held);
                end
                out_ready = 1'b1;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        check({name, "_back_idle"}, {out_valid, busy, in_ready, ovf}, 4'b0010);
    endtask

    task automatic run_product(input string name, input int bubble_pct, input int stall_row);
        model();
        send_beats(name, bubble_pct);
        collect(name, stall_row);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {in_ready, out_valid, busy, out_row, out_last, ovf}, 0);
        check({name, "_data"}, out_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int k;
        n_tests   = 0;
        n_fail    = 0;
        RST       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("ready_after_reset", {in_ready, busy, out_valid}, 3'b100);

        // Single beat: all-ones times all-twos.
        qa.delete(); qb.delete();
        qa.push_back(fill_beat(8'd1));
        qb.push_back(fill_beat(8'd2));
        run_product("single", 0, -1);
        check("single_c00", first_row[AW-1:0], 2);

        // K=16 random signed beats with bubbles.
        qa.delete(); qb.delete();
        for (int i = 0; i < 16; i++) begin
            qa.push_back(rand_beat());
            qb.push_back(rand_beat());
        end
        run_product("rand16", 35, -1);

        // Backpressure on row 3.
        qa.delete(); qb.delete();
        for (int i = 0; i < 10; i++) begin
            qa.push_back(rand_beat());
            qb.push_back(rand_beat());
        end
        run_product("stall", 20, 3);

        // K=40 of 127*127 overflows a 19-bit accumulator.
        qa.delete(); qb.delete();
        for (int i = 0; i < 40; i++) begin
            qa.push_back(fill_beat(8'h7f));
            qb.push_back(fill_beat(8'h7f));
        end
        run_product("k40", 0, -1);
`ifdef SA_SATURATE_EN
        check("k40_c00", first_row[AW-1:0], 262143);
`else
        check("k40_c00", first_row[AW-1:0], 120872);
`endif

        // Abort a product at DRAIN cycle 10, then run a fresh one.
        qa.delete(); qb.delete();
        for (int i = 0; i < 3; i++) begin
            qa.push_back(rand_beat());
            qb.push_back(rand_beat());
        end
        send_beats("abort", 0);
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check_reset_outputs("mid_drain_rst");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("ready_after_abort", {in_ready, busy, out_valid}, 3'b100);
        qa.delete(); qb.delete();
        qa.push_back(fill_beat(8'h80));
        qb.push_back(fill_beat(8'h80));
        run_product("post_abort", 0, -1);
        check("post_abort_c00", first_row[AW-1:0], 16384);

        // A few more random products of random depth.
        for (int t = 0; t < 3; t++) begin
            qa.delete(); qb.delete();
            k = $urandom_range(1, 20);
            for (int i = 0; i < k; i++) begin
                qa.push_back(rand_beat());
                qb.push_back(rand_beat());
            end
            run_product($sformatf("extra%0d", t), 25, $urandom_range(N - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
